lfsr_seq_checker: RTL and testbench

//  Receive-side companion to the 26-bit LFSR pattern generator. Takes the serial

---
 rtl/lfsr_seq_checker.sv | 134 +++++++++++++
 tb/tb_lfsr_seq_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising PRBS receive checker: hunts for the LFSR phase, verifies it,
// then flywheels on its own prediction while counting and windowing bit errors.
`timescale 1ns/1ps

module lfsr_seq_checker #(
  parameter int              WIDTH    = 26,
  parameter logic [WIDTH-1:0] TAPS    = 26'h2000023,
  parameter int              LOCK_CNT = 32,
  parameter int              LOSS_WIN = 64,
  parameter int              LOSS_ERR = 4,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(LOSS_WIN + 1);
  localparam int WERR_W  = $clog2(LOSS_ERR + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WIN - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_ERR - 1);

  state_t              cur;
  logic [WIDTH-1:0]    hist;      // hist[k] holds the bit received k+1 samples ago
  logic [FILL_W-1:0]   fill_cnt;
  logic [MATCH_W-1:0]  match_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [WERR_W-1:0]   win_err;

  logic pred;
  logic mismatch;

  assign pred     = ^(hist & TAPS);
  assign mismatch = din ^ pred;
  assign state    = cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= HUNT;
      // NOTE: the history register is cleared too, so a fresh hunt never predicts from stale bits.
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      // NOTE: non-blocking throughout; err defaults low and is overridden below, so it is a one-cycle pulse.
      err <= 1'b0;

      if (clr)
        err_cnt <= '0;
      else if (en && (cur == LOCKED) && mismatch && !(&err_cnt))
        err_cnt <= err_cnt + 1'b1;

      if (en) begin
        case (cur)
          HUNT: begin
            hist     <= {hist[WIDTH-2:0], din};
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_LAST) begin
              cur       <= VERIFY;
              match_cnt <= '0;
            end
          end

          VERIFY: begin
            hist <= {hist[WIDTH-2:0], din};
            // An all-zero history predicts 0 forever; refuse to count that as progress.
            if (hist == '0) begin
              match_cnt <= '0;
            end else if (!mismatch) begin
              if (match_cnt == MATCH_LAST) begin
                cur       <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end

          LOCKED: begin
            // Flywheel on the prediction so one bad bit cannot corrupt later predictions.
            hist <= {hist[WIDTH-2:0], pred};
            err  <= mismatch;
            if (mismatch && (win_err == WERR_LAST)) begin
              cur      <= HUNT;
              locked   <= 1'b0;
              fill_cnt <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              win_err <= win_err + WERR_W'(mismatch);
            end
          end

          default: begin
            cur    <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: segment table plus per-sample scoreboard, with
// hand-written reset, gapped-valid and stuck-line sequences.
`timescale 1ns/1ps

module tb_lfsr_seq_checker;

  localparam logic [25:0] TAPS = 26'h2000023;
  localparam logic [25:0] SEED = 26'b10010110101101000111111000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        din;
  logic        clr;

  logic        lk16, er16;
  logic [1:0]  st16;
  logic [15:0] cnt16;
  logic        lk4, er4;
  logic [1:0]  st4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  lfsr_seq_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .locked(lk16), .state(st16), .err(er16), .err_cnt(cnt16)
  );

  lfsr_seq_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .locked(lk4), .state(st4), .err(er4), .err_cnt(cnt4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference generator for the transmitted stream.
  logic [25:0] gen;

  function automatic logic gen_next();
    logic b;
    b   = ^(gen & TAPS);
    gen = {gen[24:0], b};
    return b;
  endfunction

  // Expected-behaviour model; f means din was inverted against the generator.
  typedef struct {
    logic [1:0]  st;
    logic        lk;
    logic        er;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  exp_t sb_q[$];
  int   m_st, m_fill, m_match, m_win, m_werr, m_c16, m_c4;
  int   sample_n;

  task automatic model_reset();
    m_st = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_c16 = 0; m_c4 = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic e, input logic f, input logic c);
    exp_t x;
    logic exp_err;
    exp_err = e && (m_st == 2) && f;
    if (e) begin
      if (m_st == 0) begin
        m_fill++;
        if (m_fill == 26) begin m_st = 1; m_match = 0; end
      end else if (m_st == 1) begin
        m_match++;
        if (m_match == 32) begin m_st = 2; m_win = 0; m_werr = 0; end
      end else begin
        m_win++;
        if (f) m_werr++;
        if (m_werr == 4) begin m_st = 0; m_fill = 0; end
        else if (m_win == 64) begin m_win = 0; m_werr = 0; end
      end
    end
    if (c) begin
      m_c16 = 0; m_c4 = 0;
    end else if (exp_err) begin
      if (m_c16 < 65535) m_c16++;
      if (m_c4 < 15) m_c4++;
    end
    x.st  = 2'(m_st);
    x.lk  = (m_st == 2);
    x.er  = exp_err;
    x.c16 = 16'(m_c16);
    x.c4  = 4'(m_c4);
    sb_q.push_back(x);
  endtask

  task automatic step(input logic e, input logic f, input logic c);
    exp_t x;
    logic b;
    b = 1'($urandom_range(0, 1));
    if (e) b = gen_next() ^ f;
    en  = e;
    din = b;
    clr = c;
    model_step(e, f, c);
    @(posedge clk);
    #1;
    sample_n++;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      check($sformatf("s%0d_w16 {st,lk,err,cnt}", sample_n),
            {12'd0, st16, lk16, er16, cnt16}, {12'd0, x.st, x.lk, x.er, x.c16});
      check($sformatf("s%0d_w4 {st,lk,err,cnt}", sample_n),
            {24'd0, st4, lk4, er4, cnt4}, {24'd0, x.st, x.lk, x.er, x.c4});
    end
  endtask

  task automatic do_reset(input logic e, input logic d);
    rst_n = 1'b0;
    en    = e;
    din   = d;
    clr   = 1'b0;
    @(posedge clk);
    #1;
    check("reset_w16 {st,lk,err,cnt}", {12'd0, st16, lk16, er16, cnt16}, 32'd0);
    check("reset_w4 {st,lk,err,cnt}", {24'd0, st4, lk4, er4, cnt4}, 32'd0);
    rst_n = 1'b1;
    en    = 1'b0;
    model_reset();
  endtask

  typedef struct {
    string      name;
    int         len;
    int         first;
    int         gap;
    int         nfl;
    int         clr_at;
    logic [1:0] st;
    int         c16;
    int         c4;
  } seg_t;

  seg_t segs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f, c, e;
    int   valid_n, lock_at, cyc;
    logic seen, saw_lock, saw_err;

    segs[0] = '{"clean1000",  1000, 0,  1,  0, -1, 2'd2, 0,  0};
    segs[1] = '{"single_flip",  20, 10, 1,  1, -1, 2'd2, 1,  1};
    segs[2] = '{"align",        62, 0,  1,  0, -1, 2'd2, 1,  1};
    segs[3] = '{"three_per_win",384, 5, 21, 18, -1, 2'd2, 19, 15};
    segs[4] = '{"burst_loss",   33, 2,  10, 4,  0,  2'd0, 4,  4};
    segs[5] = '{"relock_57",    57, 0,  1,  0, -1, 2'd1, 4,  4};
    segs[6] = '{"relock_58",     1, 0,  1,  0, -1, 2'd2, 4,  4};
    segs[7] = '{"clr_with_flip",10, 3,  1,  1,  3,  2'd2, 0,  0};
    segs[8] = '{"five_errs",   130, 1,  30, 5, -1, 2'd2, 5,  5};

    sample_n = 0;
    gen      = SEED;
    model_reset();
    do_reset(1'b0, 1'b0);

    for (int s = 0; s < 9; s++) begin
      for (int k = 0; k < segs[s].len; k++) begin
        f = 1'b0;
        for (int j = 0; j < segs[s].nfl; j++)
          if (k == segs[s].first + j * segs[s].gap) f = 1'b1;
        c = (k == segs[s].clr_at);
        step(1'b1, f, c);
      end
      check({segs[s].name, "_state"}, {30'd0, st16}, {30'd0, segs[s].st});
      check({segs[s].name, "_locked"}, {31'd0, lk16}, {31'd0, segs[s].st == 2'd2});
      check({segs[s].name, "_cnt16"}, {16'd0, cnt16}, 32'(segs[s].c16));
      check({segs[s].name, "_cnt4"}, {28'd0, cnt4}, 32'(segs[s].c4));
    end
    en  = 1'b0;
    clr = 1'b0;

    // Reset asserted while locked with a non-zero count and live valid data.
    do_reset(1'b1, 1'b1);

    // Gapped valid: lock must arrive on exactly the 58th valid sample.
    gen     = SEED;
    valid_n = 0;
    lock_at = 0;
    seen    = 1'b0;
    cyc     = 0;
    while (valid_n < 80 && cyc < 400) begin
      e = 1'($urandom_range(0, 1));
      step(e, 1'b0, 1'b0);
      if (e) valid_n++;
      if (!seen && lk16) begin
        seen    = 1'b1;
        lock_at = valid_n;
      end
      cyc++;
    end
    check("gapped_budget", 32'(valid_n >= 80), 32'd1);
    check("gapped_lock_at", 32'(lock_at), 32'd58);
    en = 1'b0;

    // Stuck-at-0 line: reaches VERIFY but never locks.
    do_reset(1'b0, 1'b0);
    saw_lock = 1'b0;
    saw_err  = 1'b0;
    for (int k = 0; k < 500; k++) begin
      en  = 1'b1;
      din = 1'b0;
      clr = 1'b0;
      @(posedge clk);
      #1;
      if (st16 == 2'd2 || lk16) saw_lock = 1'b1;
      if (er16) saw_err = 1'b1;
    end
    en = 1'b0;
    check("stuck_state", {30'd0, st16}, 32'd1);
    check("stuck_saw_lock", {31'd0, saw_lock}, 32'd0);
    check("stuck_saw_err", {31'd0, saw_err}, 32'd0);
    check("stuck_cnt", {16'd0, cnt16}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
